// File: rtl/sap_pkg.sv
// System-bus constants shared by the crossbar blocks: master count, fixed
// master slot indices and the OBI address-phase bundle.
package sap_pkg;

  localparam int unsigned SYSTEM_XBAR_NMASTER = 7;
  localparam int unsigned NMASTER             = SYSTEM_XBAR_NMASTER;

  localparam int unsigned CORE0_INSTR_IDX     = 0;
  localparam int unsigned CORE0_DATA_IDX      = 1;
  localparam int unsigned CORE1_INSTR_IDX     = 2;
  localparam int unsigned CORE1_DATA_IDX      = 3;
  localparam int unsigned CORE2_INSTR_IDX     = 4;
  localparam int unsigned CORE2_DATA_IDX      = 5;
  localparam int unsigned EXTERNAL_MASTER_IDX = 6;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_aphase_t;

  // Index width that stays legal for a single master.
  function automatic int unsigned idx_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sap_obi_slave_arbiter_if.sv
// Bus bundle between the NMASTER OBI master ports, the arbiter and one slave port.
// slave modport = arbiter view; master modport = surrounding masters + slave.
interface sap_obi_slave_arbiter_if #(
  parameter int unsigned NMASTER = sap_pkg::NMASTER
);
  logic [NMASTER-1:0]       master_req_i;
  logic [NMASTER-1:0][31:0] master_addr_i;
  logic [NMASTER-1:0]       master_we_i;
  logic [NMASTER-1:0][3:0]  master_be_i;
  logic [NMASTER-1:0][31:0] master_wdata_i;
  logic [NMASTER-1:0]       master_gnt_o;
  logic [NMASTER-1:0]       master_rvalid_o;
  logic [NMASTER-1:0][31:0] master_rdata_o;
  logic                     slave_req_o;
  logic [31:0]              slave_addr_o;
  logic                     slave_we_o;
  logic [3:0]               slave_be_o;
  logic [31:0]              slave_wdata_o;
  logic                     slave_gnt_i;
  logic                     slave_rvalid_i;
  logic [31:0]              slave_rdata_i;

  modport slave (
    input  master_req_i, master_addr_i, master_we_i, master_be_i, master_wdata_i,
    input  slave_gnt_i, slave_rvalid_i, slave_rdata_i,
    output master_gnt_o, master_rvalid_o, master_rdata_o,
    output slave_req_o, slave_addr_o, slave_we_o, slave_be_o, slave_wdata_o
  );

  modport master (
    output master_req_i, master_addr_i, master_we_i, master_be_i, master_wdata_i,
    output slave_gnt_i, slave_rvalid_i, slave_rdata_i,
    input  master_gnt_o, master_rvalid_o, master_rdata_o,
    input  slave_req_o, slave_addr_o, slave_we_o, slave_be_o, slave_wdata_o
  );
endinterface

// File: rtl/sap_outstanding_fifo.sv
// Small FIFO of issuing-master indices, one entry per in-flight transaction.
// Push when full and pop when empty are ignored.
module sap_outstanding_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 3,
  localparam int unsigned CW   = $clog2(DEPTH + 1),
  localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_in_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);
  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [PW-1:0]               wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]               count_q;
  logic                        do_push, do_pop;

  function automatic logic [PW-1:0] nxt(logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_in_i;
        wr_ptr_q        <= nxt(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= nxt(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/sap_obi_slave_arbiter.sv
// Round-robin OBI arbiter sharing one slave port among NMASTER masters, with
// address-phase lock and in-order response routing via an outstanding FIFO.
module sap_obi_slave_arbiter
  import sap_pkg::*;
#(
  parameter int unsigned NMASTER         = sap_pkg::NMASTER,
  parameter int unsigned MAX_OUTSTANDING = 2,
  localparam int unsigned IDX_W          = idx_w(NMASTER),
  localparam int unsigned CW             = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  sap_obi_slave_arbiter_if.slave  bus,
  output logic                    busy_o,
  output logic                    protocol_err_o
);
  logic [IDX_W-1:0] rr_q, rr_d, lock_idx_q, lock_idx_d;
  logic [IDX_W-1:0] cand, sel, head;
  logic             lock_q, lock_d, err_q, err_d;
  logic             found, sreq, hs, pop, full, empty;
  logic [CW-1:0]    count;
  int unsigned      scan_j;
  obi_aphase_t      aph;

  // First requester at or after the rr pointer, wrapping.
  always_comb begin
    cand   = '0;
    found  = 1'b0;
    scan_j = 0;
    for (int k = 0; k < int'(NMASTER); k++) begin
      scan_j = (32'(rr_q) + 32'(k)) % NMASTER;
      if (!found && bus.master_req_i[scan_j]) begin
        cand  = IDX_W'(scan_j);
        found = 1'b1;
      end
    end
  end

  // Full uses the registered count, so a same-cycle pop does not unblock.
  assign sel  = lock_q ? lock_idx_q : cand;
  assign sreq = rst_ni & ~full & (lock_q | found);
  assign hs   = sreq & bus.slave_gnt_i;
  assign pop  = rst_ni & bus.slave_rvalid_i & ~empty;

  always_comb begin
    aph = '0;
    if (sreq) aph = '{addr:  bus.master_addr_i[sel], we: bus.master_we_i[sel],
                      be:    bus.master_be_i[sel],  wdata: bus.master_wdata_i[sel]};
    bus.master_gnt_o    = '0;
    bus.master_rvalid_o = '0;
    bus.master_rdata_o  = '0;
    if (hs) bus.master_gnt_o[sel] = 1'b1;
    if (pop) begin
      bus.master_rvalid_o[head] = 1'b1;
      bus.master_rdata_o[head]  = bus.slave_rdata_i;
    end
  end

  assign bus.slave_req_o   = sreq;
  assign bus.slave_addr_o  = aph.addr;
  assign bus.slave_we_o    = aph.we;
  assign bus.slave_be_o    = aph.be;
  assign bus.slave_wdata_o = aph.wdata;
  assign busy_o            = (count != '0);
  assign protocol_err_o    = err_q;

  always_comb begin
    rr_d       = rr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    err_d      = err_q | (bus.slave_rvalid_i & empty);
    if (hs) begin
      lock_d = 1'b0;
      rr_d   = (sel == IDX_W'(NMASTER - 1)) ? '0 : sel + IDX_W'(1);
    end else if (sreq) begin
      lock_d     = 1'b1;
      lock_idx_d = sel;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      err_q      <= 1'b0;
    end else begin
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      err_q      <= err_d;
    end
  end

  sap_outstanding_fifo #(.DEPTH(MAX_OUTSTANDING), .WIDTH(IDX_W)) u_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push_i    (hs),
    .pop_i     (pop),
    .data_in_i (sel),
    .head_o    (head),
    .count_o   (count),
    .full_o    (full),
    .empty_o   (empty)
  );
endmodule
